sha1_ctrl: RTL

SHA1_CTRL -- requirements
Module: sha1_ctrl

---
 rtl/sha1_ctrl_if.sv | 27 ++
 rtl/sha1_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sha1_ctrl_if.sv
// sha1_ctrl_if: block-in / digest-out handshake between the SHA-1 round
// controller and its neighbours.
//   blk_valid  upstream offers a 512-bit block
//   blk_first  offered block starts a message   (qualified by blk_valid)
//   blk_last   offered block ends a message     (qualified by blk_valid)
//   blk_ready  controller accepts the offered block this cycle
//   dig_valid  final digest held in the datapath is valid
//   dig_ready  downstream consumes the digest
// master: block producer / digest consumer.  slave: the controller.
interface sha1_ctrl_if;
    logic blk_valid;
    logic blk_first;
    logic blk_last;
    logic blk_ready;
    logic dig_valid;
    logic dig_ready;

    modport master (
        output blk_valid, blk_first, blk_last, dig_ready,
        input  blk_ready, dig_valid
    );

    modport slave (
        input  blk_valid, blk_first, blk_last, dig_ready,
        output blk_ready, dig_valid
    );
endinterface

// File: rtl/sha1_ctrl.sv
// sha1_ctrl: sequences one SHA-1 block through the W generator / round
// datapath: a load cycle (round 0), rounds 1..ROUNDS, one H-update cycle,
// then either the digest handshake (last block) or a return to idle.
// Tracks whether a message is open and flags framing errors (sticky).
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   bus        sha1_ctrl_if.slave (block and digest handshakes)
//   dp_valid   round-0 load strobe to the W generator / datapath
//   dp_round   round index; PARK while no block is in flight
//   dp_init    datapath takes H0 constants as chaining input (load cycle)
//   dp_update  one-cycle strobe: add working variables into H
//   busy       high in every state except idle
//   err        sticky protocol error, cleared only by rst
//   blk_cnt    blocks completed in the current message
// All outputs are registered.
module sha1_ctrl #(
    parameter int              ROUNDS = 80,
    parameter int              RW     = 8,
    parameter logic [RW-1:0]   PARK   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    sha1_ctrl_if.slave        bus,
    output logic              dp_valid,
    output logic [RW-1:0]     dp_round,
    output logic              dp_init,
    output logic              dp_update,
    output logic              busy,
    output logic              err,
    output logic [15:0]       blk_cnt
);

    localparam logic [RW-1:0] LAST_RND = RW'(ROUNDS);
    localparam logic [RW-1:0] RND_ONE  = RW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_UPDATE,
        S_OUT
    } state_t;

    state_t state;
    logic   last_q;     // captured blk_last of the block in flight
    logic   msg_open;   // a non-last block has been accepted

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            last_q        <= 1'b0;
            msg_open      <= 1'b0;
            bus.blk_ready <= 1'b1;
            bus.dig_valid <= 1'b0;
            dp_valid      <= 1'b0;
            dp_round      <= PARK;
            dp_init       <= 1'b0;
            dp_update     <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
            blk_cnt       <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.blk_valid) begin
                        last_q        <= bus.blk_last;
                        msg_open      <= !bus.blk_last;
                        // Framing error: a start while a message is open,
                        // or a continuation while none is open.
                        if (bus.blk_first == msg_open) begin
                            err <= 1'b1;
                        end
                        // Any block that opens a chain (legitimately or
                        // forced after an error) starts from H0 and a
                        // fresh block count.
                        if (bus.blk_first || !msg_open) begin
                            dp_init <= 1'b1;
                            blk_cnt <= 16'd0;
                        end
                        bus.blk_ready <= 1'b0;
                        busy          <= 1'b1;
                        dp_valid      <= 1'b1;
                        dp_round      <= '0;
                        state         <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    dp_valid <= 1'b0;
                    dp_init  <= 1'b0;
                    dp_round <= RND_ONE;
                    state    <= S_ROUND;
                end

                S_ROUND: begin
                    if (dp_round == LAST_RND) begin
                        dp_update <= 1'b1;
                        dp_round  <= PARK;
                        state     <= S_UPDATE;
                    end else begin
                        dp_round <= dp_round + RND_ONE;
                    end
                end

                S_UPDATE: begin
                    dp_update <= 1'b0;
                    blk_cnt   <= blk_cnt + 16'd1;
                    if (last_q) begin
                        bus.dig_valid <= 1'b1;
                        state         <= S_OUT;
                    end else begin
                        bus.blk_ready <= 1'b1;
                        busy          <= 1'b0;
                        state         <= S_IDLE;
                    end
                end

                S_OUT: begin
                    // blk_ready stays low on the consuming edge, so a block
                    // can only be taken from the following cycle on.
                    if (bus.dig_ready) begin
                        bus.dig_valid <= 1'b0;
                        bus.blk_ready <= 1'b1;
                        busy          <= 1'b0;
                        blk_cnt       <= 16'd0;
                        state         <= S_IDLE;
                    end
                end

                default: begin
                    bus.blk_ready <= 1'b1;
                    bus.dig_valid <= 1'b0;
                    dp_valid      <= 1'b0;
                    dp_round      <= PARK;
                    dp_init       <= 1'b0;
                    dp_update     <= 1'b0;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule
